// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU), XLEN-parametrised.
// Latency: XLEN+1 cycles from accepted start to done; 1 cycle for divide-by-zero and signed overflow.
// Backpressure: busy stays high from the accepted start through the done cycle; start is only taken
//   when no operation is in flight, and the earliest taken start is at the edge that ends the done cycle.
// Ports:
//   clk, rst_n         - rising-edge clock, asynchronous active-low reset
//   start, op, a, b    - request, funct3 opcode, rs1/rs2 operands (captured when the request is taken)
//   flush              - abort any in-flight operation at the next edge (no done, result kept)
//   busy, done, result - in-flight flag, one-cycle completion pulse, registered result
module alu_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Captured request and iteration state.
  logic [2:0]      op_q;
  logic [CW-1:0]   cnt;
  logic            neg_q;   // product / quotient must be negated at the end
  logic            neg_r;   // remainder must be negated at the end (dividend was negative)
  logic [XLEN-1:0] opb;     // multiplicand or divisor magnitude
  logic [XLEN-1:0] acc_hi;  // product high half / partial remainder
  logic [XLEN-1:0] acc_lo;  // multiplier (shifts out) + product low half / dividend -> quotient

  // Request decode.
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf, accept;

  always_comb begin
    a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    a_neg    = a_signed && a[XLEN-1];
    b_neg    = b_signed && b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = op[2] && (b == '0);
    div_ovf  = ((op == 3'b100) || (op == 3'b110)) && (a == MIN_NEG) && (b == '1);
    // The done cycle is already back in IDLE, so a held start is taken at the edge ending it.
    accept   = start && (state == IDLE) && !flush;
  end

  // One iteration step for each algorithm.
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_sh;
  logic            div_ge;
  logic [XLEN-1:0] div_dif;

  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    div_sh  = {acc_hi, acc_lo[XLEN-1]};
    // A set top bit means the shifted remainder already exceeds any XLEN-bit divisor; the
    // true difference is then below the divisor, so the low XLEN bits of the subtraction suffice.
    div_ge  = div_sh[XLEN] || (div_sh[XLEN-1:0] >= opb);
    div_dif = div_sh[XLEN-1:0] - opb;
  end

  // Sign correction and output selection.
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fin_val;

  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -acc_lo : acc_lo;
    rem_fix  = neg_r ? -acc_hi : acc_hi;
    fin_val  = rem_fix;
    case (op_q)
      3'b000:                 fin_val = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_val = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_val = quo_fix;
      default:                fin_val = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (div_zero || div_ovf) ? FIN : CALC;
      CALC:    if (cnt == CW'(1)) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opb    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= op;
            cnt  <= CW'(XLEN);
            opb  <= b_mag;
            if (div_zero) begin
              // Quotient all ones, remainder = dividend, no sign fix-up.
              acc_lo <= '1;
              acc_hi <= a;
              neg_q  <= 1'b0;
              neg_r  <= 1'b0;
            end else if (div_ovf) begin
              // Quotient = dividend (most negative value), remainder zero.
              acc_lo <= a;
              acc_hi <= '0;
              neg_q  <= 1'b0;
              neg_r  <= 1'b0;
            end else begin
              acc_lo <= a_mag;
              acc_hi <= '0;
              neg_q  <= a_neg ^ b_neg;
              neg_r  <= a_neg;
            end
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (op_q[2]) begin
            // Restoring division: shift in one dividend bit, subtract if it fits.
            acc_hi <= div_ge ? div_dif : div_sh[XLEN-1:0];
            acc_lo <= {acc_lo[XLEN-2:0], div_ge};
          end else begin
            // Shift-add: the multiplier drains out of acc_lo as the product fills in.
            acc_hi <= mul_sum[XLEN:1];
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
          end
        end
        FIN: begin
          if (!flush) begin
            result <= fin_val;
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE) || done;

endmodule

// File: tb/tb_alu_muldiv.sv
// Bench for alu_muldiv: 32-bit instance checked every cycle against a timeline/arithmetic model,
// plus directed literal cases and a 64-bit instance.
// Stimulus is driven on the falling edge; outputs are sampled on the falling edge.
module tb_alu_muldiv;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = 3'd0;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  logic        start64 = 1'b0;
  logic [2:0]  op64    = 3'd0;
  logic [63:0] a64     = 64'd0;
  logic [63:0] b64     = 64'd0;
  logic        flush64 = 1'b0;
  logic        busy64, done64;
  logic [63:0] result64;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int cyc    = 0;

  alu_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  alu_muldiv #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .op(op64), .a(a64), .b(b64), .flush(flush64),
    .busy(busy64), .done(done64), .result(result64)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at t=%0t", nm, got, exp, $time);
    end
  endtask

  // RV32M semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic [63:0] ux, uy, p;
    logic [31:0] r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'd0, x};
    uy = {32'd0, y};
    r  = 32'd0;
    case (o)
      3'd0: begin p = ux * uy; r = p[31:0]; end
      3'd1: begin p = sx * sy; r = p[63:32]; end
      3'd2: begin p = sx * $signed(uy); r = p[63:32]; end
      3'd3: begin p = ux * uy; r = p[63:32]; end
      3'd4: begin
        if (y == 32'd0) r = 32'hFFFFFFFF;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = x;
        else begin p = sx / sy; r = p[31:0]; end
      end
      3'd5: r = (y == 32'd0) ? 32'hFFFFFFFF : x / y;
      3'd6: begin
        if (y == 32'd0) r = x;
        else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'd0;
        else begin p = sx % sy; r = p[31:0]; end
      end
      default: r = (y == 32'd0) ? x : x % y;
    endcase
    return r;
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    return o[2] && ((y == 32'd0) ||
                    ((o == 3'd4 || o == 3'd6) && x == 32'h80000000 && y == 32'hFFFFFFFF));
  endfunction

  // Timeline model: cycles remaining until done, pending result, registered result.
  int          m_rem    = 0;
  bit          m_done   = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pend   = 32'd0;
  int          m_dones  = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem    = 0;
      m_done   = 1'b0;
      m_result = 32'd0;
    end else begin
      m_done = 1'b0;
      if (flush) begin
        m_rem = 0;
      end else if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_done   = 1'b1;
          m_result = m_pend;
          m_dones++;
        end
      end else if (start) begin
        m_pend = model(op, a, b);
        m_rem  = is_special(op, a, b) ? 1 : 33;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("done",   64'(done),   64'(m_done));
      check("busy",   64'(busy),   64'((m_rem > 0) || m_done));
      check("result", 64'(result), 64'(m_result));
    end
  end

  function automatic logic [31:0] rnd_opnd();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'hFFFFFFFF;
      2:       v = 32'h80000000;
      3:       v = 32'($urandom_range(0, 15));
      default: v = $urandom();
    endcase
    return v;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    check("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int lat);
    int n;
    wait_idle();
    check({nm, "_model"}, 64'(model(o, x, y)), 64'(exp));
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin @(negedge clk); n++; end
    check({nm, "_lat"}, 64'(n), 64'(lat));
    check(nm, 64'(result), 64'(exp));
  endtask

  task automatic run64(input string nm, input logic [2:0] o, input logic [63:0] x,
                       input logic [63:0] y, input logic [63:0] exp, input int lat);
    int n;
    n = 0;
    while (busy64 && n < 200) begin @(negedge clk); n++; end
    start64 = 1'b1; op64 = o; a64 = x; b64 = y;
    @(negedge clk);
    start64 = 1'b0;
    n = 0;
    while (!done64 && n < 200) begin @(negedge clk); n++; end
    check({nm, "_lat"}, 64'(n), 64'(lat));
    check(nm, result64, exp);
  endtask

  initial begin
    int n, ndone;
    int dcyc[3];
    logic [2:0]   o;
    logic [63:0]  x, y, e;
    logic [127:0] p;
    logic [2:0]   ops64[4];
    ops64 = '{3'd0, 3'd3, 3'd5, 3'd7};

    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",     64'(busy),   64'd0);
    check("rst_done",     64'(done),   64'd0);
    check("rst_result",   64'(result), 64'd0);
    check("rst_busy64",   64'(busy64), 64'd0);
    check("rst_result64", result64,    64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul",    3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulhu",  3'd3, 32'd7, 32'hFFFFFFFD, 32'h00000006, 33);
    run_op("mulh",   3'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 33);
    run_op("div",    3'd4, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    run_op("rem",    3'd6, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    run_op("divu",   3'd5, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 33);
    run_op("divu_z", 3'd5, 32'h1234, 32'd0, 32'hFFFFFFFF, 1);
    run_op("rem_z",  3'd6, 32'h1234, 32'd0, 32'h00001234, 1);
    run_op("div_ov", 3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);

    // Flush ten cycles into a divide.
    wait_idle();
    start = 1'b1; op = 3'd4; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    ndone = 0;
    repeat (50) begin @(negedge clk); if (done) ndone++; end
    check("flush_no_done", 64'(ndone), 64'd0);
    check("flush_result",  64'(result), 64'h80000000);
    run_op("mul_after_flush", 3'd0, 32'd12345, 32'd678, 32'h007FB6F6, 33);

    // Asynchronous reset in the middle of a MULH.
    wait_idle();
    start = 1'b1; op = 3'd1; a = 32'h12345678; b = 32'h9ABCDEF0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",   64'(busy),   64'd0);
    check("arst_done",   64'(done),   64'd0);
    check("arst_result", 64'(result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33);

    // A start pulse during CALC must be ignored.
    wait_idle();
    start = 1'b1; op = 3'd5; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    n = 6;
    while (!done && n < 100) begin @(negedge clk); n++; end
    check("ignore_lat",    64'(n), 64'd33);
    check("ignore_result", 64'(result), 64'd142);
    ndone = 0;
    repeat (40) begin @(negedge clk); if (done) ndone++; end
    check("ignore_no_extra", 64'(ndone), 64'd0);

    // Start held high across three operations.
    wait_idle();
    start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5;
    ndone = 0; n = 0;
    dcyc = '{0, 0, 0};
    while (ndone < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin dcyc[ndone] = cyc; ndone++; end
    end
    start = 1'b0;
    check("held_count",  64'(ndone), 64'd3);
    check("held_gap1",   64'(dcyc[1] - dcyc[0]), 64'd34);
    check("held_gap2",   64'(dcyc[2] - dcyc[1]), 64'd34);
    check("held_result", 64'(result), 64'd15);

    // Randomised traffic with occasional flushes; checked every cycle by the compare process.
    wait_idle();
    ndone = m_dones;
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = rnd_opnd();
      b     = ($urandom_range(0, 7) == 0) ? 32'd0 : rnd_opnd();
      flush = ($urandom_range(0, 79) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    flush = 1'b0;
    wait_idle();
    check("random_activity", 64'((m_dones - ndone) > 20), 64'd1);

    // 64-bit instance.
    run64("mulhu64", 3'd3, 64'h8000000000000000, 64'd4, 64'd2, 65);
    for (int i = 0; i < 6; i++) begin
      o = ops64[$urandom_range(0, 3)];
      x = {$urandom(), $urandom()};
      y = ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom(), $urandom()};
      if (i == 1) y = 64'd0;
      p = {64'd0, x} * {64'd0, y};
      case (o)
        3'd0:    e = p[63:0];
        3'd3:    e = p[127:64];
        3'd5:    e = (y == 64'd0) ? 64'hFFFFFFFFFFFFFFFF : x / y;
        default: e = (y == 64'd0) ? x : x % y;
      endcase
      run64("rand64", o, x, y, e, (o[2] && y == 64'd0) ? 1 : 65);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
